// File: rtl/krets_pkg.sv
// krets_pkg: shared types and helpers for the krets operation sequencer.
//   op_t      - operation codes as seen on in_op
//   state_t   - sequencer states
//   KRETS_W   - datapath width of the downstream invert/increment unit
//   op_to_en  - maps an operation onto the unit's {EN2, EN1} controls
package krets_pkg;

    localparam int KRETS_W = 4;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_INC  = 2'b01,
        OP_INV  = 2'b10,
        OP_NEG  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Returns {en2 (carry-in), en1 (invert)}.
    function automatic logic [1:0] op_to_en(op_t op);
        logic [1:0] en;
        case (op)
            OP_PASS: en = 2'b00;
            OP_INC:  en = 2'b10;
            OP_INV:  en = 2'b01;
            default: en = 2'b11;  // OP_NEG
        endcase
        return en;
    endfunction

endpackage

// File: rtl/krets_op_seq.sv
// krets_op_seq: sequencing stage in front of the 4-bit invert/increment unit.
// Accepts one request (in_*), drives the unit from registers (u_en2/u_en1/u_di),
// captures the unit result one cycle later (u_do/u_co) with zero/overflow flags
// and an accumulator, then presents it on out_* until out_ready.
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             request handshake
//   in_op, in_src_acc, in_data    operation, operand select, operand
//   acc_clr                       accumulator clear, honoured in IDLE only
//   u_en2, u_en1, u_di            registered drive to the unit
//   u_do, u_co                    combinational result from the unit
//   out_valid/out_ready           result handshake
//   out_data, out_co, out_zero, out_ovf, acc   captured result and accumulator
module krets_op_seq
    import krets_pkg::*;
#(
    parameter int WIDTH = KRETS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_src_acc,
    input  logic [WIDTH-1:0] in_data,
    input  logic             acc_clr,
    output logic             u_en2,
    output logic             u_en1,
    output logic [WIDTH-1:0] u_di,
    input  logic [WIDTH-1:0] u_do,
    input  logic             u_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_co,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [WIDTH-1:0] acc
);

    // Operands whose INC / NEG overflows in two's complement.
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic             en2_q, en2_d, en1_q, en1_d;
    logic [WIDTH-1:0] di_q, di_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             co_q, co_d, zero_q, zero_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             in_fire;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] opnd_sel;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RESP);
    assign in_fire   = in_valid && in_ready;

    // A clear in the same cycle as a request takes effect before operand select.
    assign acc_eff  = acc_clr ? '0 : acc_q;
    assign opnd_sel = in_src_acc ? acc_eff : in_data;

    always_comb begin
        state_d = state_q;
        en2_d   = en2_q;
        en1_d   = en1_q;
        di_d    = di_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        data_d  = data_q;
        co_d    = co_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                acc_d = acc_eff;
                if (in_fire) begin
                    {en2_d, en1_d} = op_to_en(op_t'(in_op));
                    di_d    = opnd_sel;
                    op_d    = op_t'(in_op);
                    opnd_d  = opnd_sel;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                data_d  = u_do;
                co_d    = u_co;
                zero_d  = (u_do == '0);
                ovf_d   = ((op_q == OP_INC) && (opnd_q == MAX_POS)) ||
                          ((op_q == OP_NEG) && (opnd_q == MIN_NEG));
                acc_d   = u_do;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    en2_d   = 1'b0;
                    en1_d   = 1'b0;
                    di_d    = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            en2_q   <= 1'b0;
            en1_q   <= 1'b0;
            di_q    <= '0;
            op_q    <= OP_PASS;
            opnd_q  <= '0;
            data_q  <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            en2_q   <= en2_d;
            en1_q   <= en1_d;
            di_q    <= di_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            data_q  <= data_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
        end
    end

    assign u_en2    = en2_q;
    assign u_en1    = en1_q;
    assign u_di     = di_q;
    assign out_data = data_q;
    assign out_co   = co_q;
    assign out_zero = zero_q;
    assign out_ovf  = ovf_q;
    assign acc      = acc_q;

endmodule

// File: tb/tb_krets_op_seq.sv
// Directed bench for krets_op_seq with a behavioural stand-in for the
// invert/increment unit: DO = (EN1 ? ~DI : DI) + EN2, CO = carry out.
module tb_krets_op_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [1:0] in_op;
    logic       in_src_acc;
    logic [3:0] in_data;
    logic       acc_clr;
    logic       u_en2, u_en1;
    logic [3:0] u_di, u_do;
    logic       u_co;
    logic       out_valid, out_ready;
    logic [3:0] out_data;
    logic       out_co, out_zero, out_ovf;
    logic [3:0] acc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Downstream unit model.
    assign {u_co, u_do} = {1'b0, (u_en1 ? ~u_di : u_di)} + {4'b0000, u_en2};

    krets_op_seq #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src_acc(in_src_acc), .in_data(in_data), .acc_clr(acc_clr),
        .u_en2(u_en2), .u_en1(u_en1), .u_di(u_di), .u_do(u_do), .u_co(u_co),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_co(out_co), .out_zero(out_zero), .out_ovf(out_ovf), .acc(acc)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation with out_ready high; handshake on the first posedge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic src,
                          input logic [3:0] data, input logic [3:0] exp_data,
                          input logic exp_co, input logic exp_zero, input logic exp_ovf);
        @(negedge clk);
        chk({tag, ".in_ready"}, {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1; in_op = op; in_src_acc = src; in_data = data;
        @(negedge clk);                       // EXEC
        in_valid = 1'b0;
        chk({tag, ".exec_valid"}, {7'd0, out_valid}, 8'd0);
        @(negedge clk);                       // RESP, N+2
        chk({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
        chk({tag, ".data"}, {4'd0, out_data}, {4'd0, exp_data});
        chk({tag, ".flags"}, {5'd0, out_co, out_zero, out_ovf}, {5'd0, exp_co, exp_zero, exp_ovf});
        chk({tag, ".acc"}, {4'd0, acc}, {4'd0, exp_data});
        @(negedge clk);                       // back in IDLE
        chk({tag, ".drop"}, {2'd0, out_valid, u_en2, u_en1, 3'd0} | {4'd0, u_di}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_src_acc = 1'b0;
        in_data = 4'h0; acc_clr = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset.ready_valid", {6'd0, in_ready, out_valid}, 8'b10);
        chk("reset.unit", {2'd0, u_en2, u_en1, u_di}, 8'd0);
        chk("reset.out", {out_data, out_co, out_zero, out_ovf, 1'b0}, 8'd0);
        chk("reset.acc", {4'd0, acc}, 8'd0);
        @(negedge clk); rst = 1'b0;

        run_op("pass5",   2'b00, 1'b0, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0);
        run_op("neg3",    2'b11, 1'b0, 4'b0011, 4'b1101, 1'b0, 1'b0, 1'b0);
        run_op("negacc",  2'b11, 1'b1, 4'b0000, 4'b0011, 1'b0, 1'b0, 1'b0);
        run_op("incF",    2'b01, 1'b0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
        run_op("inc7",    2'b01, 1'b0, 4'b0111, 4'b1000, 1'b0, 1'b0, 1'b1);
        run_op("neg8",    2'b11, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1);
        run_op("neg0",    2'b11, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
        run_op("inv6",    2'b10, 1'b0, 4'b0110, 4'b1001, 1'b0, 1'b0, 1'b0);
        run_op("pass6i",  2'b00, 1'b1, 4'b0000, 4'b1001, 1'b0, 1'b0, 1'b0);

        // Backpressure: PASS 1010, then hold a second request (INC from acc,
        // with acc_clr) while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 2'b00; in_src_acc = 1'b0; in_data = 4'b1010;
        @(negedge clk);                       // EXEC
        in_op = 2'b01; in_src_acc = 1'b1; in_data = 4'b0000; acc_clr = 1'b1;
        chk("bp.exec_drive", {2'd0, u_en2, u_en1, u_di}, 8'b0000_1010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);                   // RESP, stalled
            chk("bp.in_ready", {6'd0, in_ready, out_valid}, 8'b01);
            chk("bp.data", {4'd0, out_data}, 8'h0A);
            chk("bp.acc_hold", {4'd0, acc}, 8'h0A);
        end
        out_ready = 1'b1;
        @(negedge clk);                       // IDLE, held request fires on next edge
        chk("bp.idle", {6'd0, in_ready, out_valid}, 8'b10);
        chk("bp.unit_clr", {2'd0, u_en2, u_en1, u_di}, 8'd0);
        @(negedge clk);                       // EXEC of INC(cleared acc)
        in_valid = 1'b0; acc_clr = 1'b0;
        chk("clr.drive", {2'd0, u_en2, u_en1, u_di}, 8'b0010_0000);
        @(negedge clk);                       // RESP
        chk("clr.valid", {7'd0, out_valid}, 8'd1);
        chk("clr.data", {4'd0, out_data}, 8'h01);
        chk("clr.acc", {4'd0, acc}, 8'h01);

        // acc_clr in RESP is ignored.
        out_ready = 1'b0;
        run_op_hold: begin
            @(negedge clk);
            acc_clr = 1'b1;
            @(negedge clk);
            chk("resp_clr.acc", {4'd0, acc}, 8'h01);
            acc_clr = 1'b0;
            out_ready = 1'b1;
        end

        // Reset during EXEC.
        @(negedge clk);                       // IDLE
        in_valid = 1'b1; in_op = 2'b01; in_src_acc = 1'b0; in_data = 4'b0011;
        @(negedge clk);                       // EXEC
        in_valid = 1'b0;
        chk("rst.pre", {2'd0, u_en2, u_en1, u_di}, 8'b0010_0011);
        #2 rst = 1'b1;
        #1;
        chk("rst.valid", {6'd0, in_ready, out_valid}, 8'b10);
        chk("rst.unit", {2'd0, u_en2, u_en1, u_di}, 8'd0);
        chk("rst.acc", {4'd0, acc}, 8'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst.still_idle", {6'd0, in_ready, out_valid}, 8'b10);
        run_op("post_rst", 2'b01, 1'b0, 4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
